// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx: PS/2 device-to-host receiver feeding the ZX keyboard matrix mapper.
// The raw kbd_clk/kbd_data pins are synchronised and kbd_clk is deglitched.
// The receiver deframes 11-bit frames and packs prefix bytes (E0/F0/E1) with the
// byte that follows them into one 32-bit scancode, presented as kbd_key.
// Optional feature: define PS2_TYPEMATIC_SUPPRESS_EN to drop repeated make codes
// (typematic repeats) until a break code, reset or receive error is seen.
module ps2_scancode_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        kbd_clk,
    input  logic        kbd_data,
    output logic [31:0] kbd_key,
    output logic        kbd_key_valid,
    output logic        rx_error
);

    localparam int              TO_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]      FILT_LAST = 8'(FILTER_LEN - 1);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]      PFX_E0    = 8'hE0;
    localparam logic [7:0]      PFX_E1    = 8'hE1;
    localparam logic [7:0]      PFX_F0    = 8'hF0;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic            clk_sync_p0, clk_sync_p1;
    logic            data_sync_p0, data_sync_p1;
    logic            filt_clk;
    logic [7:0]      filt_cnt;
    logic            filt_toggle;
    logic            fall;
    state_t          state, state_next;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift_reg;
    logic            parity_bit;
    logic [TO_W-1:0] to_cnt;
    logic            timeout;
    logic            byte_done;
    logic            frame_err;
    logic [31:0]     acc;
    logic [31:0]     acc_shift;
    logic            e1_hold;

    // Stage p0/p1: two-flop synchronisers on both pins, idling high like the bus
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_p0  <= 1'b1;
            clk_sync_p1  <= 1'b1;
            data_sync_p0 <= 1'b1;
            data_sync_p1 <= 1'b1;
        end else begin
            clk_sync_p0  <= kbd_clk;
            clk_sync_p1  <= clk_sync_p0;
            data_sync_p0 <= kbd_data;
            data_sync_p1 <= data_sync_p0;
        end
    end

    // The filtered clock only flips after FILTER_LEN consecutive disagreeing samples
    assign filt_toggle = (clk_sync_p1 != filt_clk) && (filt_cnt == FILT_LAST);
    assign fall        = filt_toggle && filt_clk;

    // Run-length deglitch filter on the synchronised clock
    always_ff @(posedge clk) begin
        if (reset) begin
            filt_clk <= 1'b1;
            filt_cnt <= 8'd0;
        end else if (clk_sync_p1 == filt_clk) begin
            filt_cnt <= 8'd0;
        end else if (filt_toggle) begin
            filt_clk <= ~filt_clk;
            filt_cnt <= 8'd0;
        end else begin
            filt_cnt <= filt_cnt + 8'd1;
        end
    end

    // A stalled frame is abandoned; a coincident falling edge always wins
    assign timeout = (state != IDLE) && !fall && (to_cnt == TO_LAST);

    // Frame state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Frame sequencing on filtered falling edges, with stop/parity/start/timeout checks
    always_comb begin
        state_next = state;
        byte_done  = 1'b0;
        frame_err  = 1'b0;
        case (state)
            IDLE: begin
                if (fall) begin
                    if (!data_sync_p1) state_next = DATA;
                    else               frame_err  = 1'b1;
                end
            end
            DATA: begin
                if (fall && (bit_cnt == 3'd7)) state_next = PARITY;
            end
            PARITY: begin
                if (fall) state_next = STOP;
            end
            STOP: begin
                if (fall) begin
                    state_next = IDLE;
                    if (data_sync_p1 && (^{shift_reg, parity_bit})) byte_done = 1'b1;
                    else                                            frame_err = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        if (timeout) begin
            state_next = IDLE;
            frame_err  = 1'b1;
        end
    end

    // Bit counter and mid-frame inactivity timer
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt <= 3'd0;
            to_cnt  <= '0;
        end else begin
            if ((state == IDLE) || fall) to_cnt <= '0;
            else                         to_cnt <= to_cnt + TO_W'(1);
            if (state == IDLE)               bit_cnt <= 3'd0;
            else if ((state == DATA) && fall) bit_cnt <= bit_cnt + 3'd1;
        end
    end

    // Data bits arrive LSB first, so shift right and insert at the MSB
    always_ff @(posedge clk) begin
        if (fall && (state == DATA))   shift_reg  <= {data_sync_p1, shift_reg[7:1]};
        if (fall && (state == PARITY)) parity_bit <= data_sync_p1;
    end

    assign acc_shift = {acc[23:0], shift_reg};

`ifdef PS2_TYPEMATIC_SUPPRESS_EN
    logic [31:0] last_make;
    logic        last_make_vld;
    logic        has_break;
    logic        repeat_hit;

    assign has_break  = (acc_shift[31:24] == PFX_F0) || (acc_shift[23:16] == PFX_F0) ||
                        (acc_shift[15:8]  == PFX_F0) || (acc_shift[7:0]   == PFX_F0);
    assign repeat_hit = last_make_vld && !has_break && (acc_shift == last_make);
`endif

    // Scancode assembly: prefixes accumulate, the final byte emits the whole word
    always_ff @(posedge clk) begin
        if (reset) begin
            acc           <= '0;
            e1_hold       <= 1'b0;
            kbd_key       <= '0;
            kbd_key_valid <= 1'b0;
            rx_error      <= 1'b0;
`ifdef PS2_TYPEMATIC_SUPPRESS_EN
            last_make_vld <= 1'b0;
`endif
        end else begin
            kbd_key_valid <= 1'b0;
            rx_error      <= 1'b0;
            if (frame_err) begin
                rx_error <= 1'b1;
                acc      <= '0;
                e1_hold  <= 1'b0;
`ifdef PS2_TYPEMATIC_SUPPRESS_EN
                last_make_vld <= 1'b0;
`endif
            end else if (byte_done) begin
                if ((shift_reg == PFX_E0) || (shift_reg == PFX_F0)) begin
                    acc <= acc_shift;
                end else if (shift_reg == PFX_E1) begin
                    acc     <= acc_shift;
                    e1_hold <= 1'b1;
                end else if (e1_hold) begin
                    // The byte following E1 belongs to the pause sequence, not a key
                    acc     <= acc_shift;
                    e1_hold <= 1'b0;
                end else begin
                    acc <= '0;
`ifdef PS2_TYPEMATIC_SUPPRESS_EN
                    if (has_break) begin
                        kbd_key       <= acc_shift;
                        kbd_key_valid <= 1'b1;
                        last_make_vld <= 1'b0;
                    end else if (!repeat_hit) begin
                        kbd_key       <= acc_shift;
                        kbd_key_valid <= 1'b1;
                        last_make     <= acc_shift;
                        last_make_vld <= 1'b1;
                    end
`else
                    kbd_key       <= acc_shift;
                    kbd_key_valid <= 1'b1;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// tb_ps2_scancode_rx: directed and randomized PS/2 frames against a byte-queue
// reference model of scancode assembly. Honours PS2_TYPEMATIC_SUPPRESS_EN.
module tb_ps2_scancode_rx;

    localparam int FLEN = 8;
    localparam int TOC  = 3000;
`ifdef PS2_TYPEMATIC_SUPPRESS_EN
    localparam bit SUPPRESS = 1'b1;
`else
    localparam bit SUPPRESS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        kbd_clk = 1'b1;
    logic        kbd_data = 1'b1;
    logic [31:0] kbd_key;
    logic        kbd_key_valid;
    logic        rx_error;

    ps2_scancode_rx #(.FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TOC)) dut (
        .clk(clk),
        .reset(reset),
        .kbd_clk(kbd_clk),
        .kbd_data(kbd_data),
        .kbd_key(kbd_key),
        .kbd_key_valid(kbd_key_valid),
        .rx_error(rx_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;

    // observed strobes
    logic [31:0] obs_q[$];
    int obs_err = 0;
    int both_hi = 0;
    int last_valid_cyc = -1;
    int last_err_cyc = -1;

    always @(negedge clk) begin
        if (kbd_key_valid === 1'b1) begin
            obs_q.push_back(kbd_key);
            last_valid_cyc = cyc;
        end
        if (rx_error === 1'b1) begin
            obs_err++;
            last_err_cyc = cyc;
        end
        if ((kbd_key_valid === 1'b1) && (rx_error === 1'b1)) both_hi++;
    end

    // reference model state
    logic [7:0]  pend[$];
    bit          absorb = 1'b0;
    bit          rec_v = 1'b0;
    logic [31:0] rec = '0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_key = '0;
    int          exp_err = 0;

    task automatic model_byte(input logic [7:0] b);
        logic [31:0] w;
        bit brk;
        int s;
        pend.push_back(b);
        if ((b == 8'hE0) || (b == 8'hF0)) return;
        if (b == 8'hE1) begin
            absorb = 1'b1;
            return;
        end
        if (absorb) begin
            absorb = 1'b0;
            return;
        end
        s = (pend.size() > 4) ? pend.size() - 4 : 0;
        w = '0;
        brk = 1'b0;
        for (int i = s; i < pend.size(); i++) begin
            w = w * 256 + 32'(pend[i]);
            if (pend[i] == 8'hF0) brk = 1'b1;
        end
        pend.delete();
        if (!(SUPPRESS && !brk && rec_v && (w == rec))) begin
            exp_q.push_back(w);
            exp_key = w;
        end
        if (brk) rec_v = 1'b0;
        else begin
            rec = w;
            rec_v = 1'b1;
        end
    endtask

    task automatic model_error();
        pend.delete();
        absorb = 1'b0;
        rec_v = 1'b0;
        exp_err++;
    endtask

    task automatic model_reset();
        pend.delete();
        absorb = 1'b0;
        rec_v = 1'b0;
        exp_key = '0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // PS/2 device driver
    int hp = 20;
    int t_fall = 0;

    task automatic ps2_bit(input logic d);
        kbd_data = d;
        repeat (hp) @(negedge clk);
        kbd_clk = 1'b0;
        t_fall = cyc;
        repeat (hp) @(negedge clk);
        kbd_clk = 1'b1;
    endtask

    // kind: 0 good, 1 bad parity, 2 bad stop
    task automatic send_frame(input logic [7:0] b, input int kind);
        logic par;
        par = ~^b;
        if (kind == 1) par = ~par;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
        ps2_bit((kind == 2) ? 1'b0 : 1'b1);
        kbd_data = 1'b1;
        repeat (hp) @(negedge clk);
    endtask

    task automatic send_good(input logic [7:0] b);
        send_frame(b, 0);
        model_byte(b);
    endtask

    task automatic send_bad(input logic [7:0] b, input int kind);
        send_frame(b, kind);
        model_error();
    endtask

    task automatic check_emits(input string tag);
        repeat (FLEN + 8) @(negedge clk);
        chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; (i < obs_q.size()) && (i < exp_q.size()); i++)
            chk(tag, obs_q[i], exp_q[i]);
        chk({tag, "_errs"}, 32'(obs_err), 32'(exp_err));
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        repeat (120000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted at %0d, required finish earlier", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t_stall;
        logic [7:0] code;
        int form;

        @(negedge clk);
        repeat (4) @(negedge clk);
        chk("reset_key", kbd_key, 32'h0);
        chk("reset_valid", {31'b0, kbd_key_valid}, 32'h0);
        chk("reset_err", {31'b0, rx_error}, 32'h0);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        send_good(8'h1C);
        chk("a_make_latency", 32'(last_valid_cyc - t_fall), 32'(FLEN + 2));
        check_emits("a_make");
        chk("a_make_hold", kbd_key, exp_key);

        send_good(8'hF0); send_good(8'h1C);
        check_emits("break_a");
        send_good(8'hE0); send_good(8'hF0); send_good(8'h75);
        check_emits("ext_break");

        send_good(8'hE1); send_good(8'h14); send_good(8'h77); send_good(8'hE1);
        send_good(8'hF0); send_good(8'h14); send_good(8'hF0); send_good(8'h77);
        check_emits("pause");

        send_good(8'hF0);
        send_bad(8'h1C, 1);
        chk("parity_key_hold", kbd_key, exp_key);
        check_emits("bad_parity");
        send_good(8'h1B);
        check_emits("after_parity");

        send_bad(8'h33, 2);
        check_emits("bad_stop");

        ps2_bit(1'b1);
        kbd_data = 1'b1;
        repeat (hp) @(negedge clk);
        model_error();
        check_emits("bad_start");

        send_good(8'h1C); send_good(8'h1C); send_good(8'h1C);
        send_good(8'hF0); send_good(8'h1C); send_good(8'h1C);
        check_emits("typematic");

        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
        t_stall = t_fall;
        repeat (TOC + TOC / 5) @(negedge clk);
        chk("timeout_delay", 32'(last_err_cyc - t_stall), 32'(TOC + FLEN + 2));
        model_error();
        check_emits("timeout");
        send_good(8'h2A);
        check_emits("after_timeout");

        for (int i = 0; i < 5; i++) begin
            kbd_clk = 1'b0;
            repeat (4) @(negedge clk);
            kbd_clk = 1'b1;
            repeat (20) @(negedge clk);
        end
        check_emits("glitch");

        send_good(8'hE0);
        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
        kbd_data = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("midreset_key", kbd_key, 32'h0);
        reset = 1'b0;
        model_reset();
        repeat (20) @(negedge clk);
        send_good(8'h2A);
        check_emits("after_midreset");

        code = 8'h1C;
        for (int g = 0; g < 24; g++) begin
            hp = $urandom_range(12, 24);
            if ($urandom_range(0, 7) == 0)
                send_bad(8'($urandom_range(1, 127)), $urandom_range(1, 2));
            if ($urandom_range(0, 2) != 0) code = 8'($urandom_range(1, 127));
            form = $urandom_range(0, 3);
            case (form)
                0: send_good(code);
                1: begin send_good(8'hF0); send_good(code); end
                2: begin send_good(8'hE0); send_good(code); end
                default: begin send_good(8'hE0); send_good(8'hF0); send_good(code); end
            endcase
            check_emits("rand");
        end
        chk("rand_key_hold", kbd_key, exp_key);

        chk("never_both", 32'(both_hi), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
